// File: rtl/cn_flipflop_bank.sv
// Bank of WIDTH CN flip-flops (n=0 hold, n=1/c=0 clear, n=1/c=1 toggle) that can also chain into an up-counter.
// Optional CN_STICKY_EN macro adds the sticky_clr input and the per-bit toggled flag output.
module cn_flipflop_bank #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] n,
    input  logic             cnt_en,
    input  logic             sclr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
`ifdef CN_STICKY_EN
    input  logic             sticky_clr,
    output logic [WIDTH-1:0] toggled,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] low_ones;
    logic [WIDTH-1:0] cell_n;
    logic [WIDTH-1:0] cell_c;
    logic [WIDTH-1:0] cell_next;

    // In counter mode every cell is a toggle cell whose N is the carry from the bits below it.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            if (gi == 0) begin : g_lsb
                assign low_ones[gi] = 1'b1;
            end else begin : g_upper
                assign low_ones[gi] = &q_reg[gi-1:0];
            end
            assign cell_n[gi]    = mode ? (cnt_en & low_ones[gi]) : n[gi];
            assign cell_c[gi]    = mode ? 1'b1 : c[gi];
            assign cell_next[gi] = cell_n[gi] ? (cell_c[gi] ? ~q_reg[gi] : 1'b0) : q_reg[gi];
        end
    endgenerate

    always_comb begin
        q_next = cell_next;
        if (sclr) begin
            q_next = '0;
        end else if (load) begin
            q_next = load_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_reg <= RESET_VAL;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q    = q_reg;
    assign qbar = ~q_reg;
    assign tc   = mode & cnt_en & (&q_reg) & ~sclr & ~load;

`ifdef CN_STICKY_EN
    logic [WIDTH-1:0] toggled_reg;
    logic [WIDTH-1:0] toggled_next;
    logic [WIDTH-1:0] tog_evt;

    // Only genuine toggles flag a bit; clears, loads and sclr never do.
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_sticky
            assign tog_evt[gi] = cell_n[gi] & cell_c[gi] & ~sclr & ~load;
        end
    endgenerate

    always_comb begin
        toggled_next = toggled_reg;
        if (sclr || sticky_clr) begin
            toggled_next = '0;
        end
        toggled_next = toggled_next | tog_evt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            toggled_reg <= '0;
        end else begin
            toggled_reg <= toggled_next;
        end
    end

    assign toggled = toggled_reg;
`endif

endmodule

// File: tb/tb_cn_flipflop_bank.sv
// Directed plus randomized bench for cn_flipflop_bank against a value-level reference model.
module tb_cn_flipflop_bank;

    localparam int         W  = 4;
    localparam logic [3:0] RV = 4'b1010;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mode, cnt_en, sclr, load, sticky_clr;
    logic [3:0] c, n, load_data;
    logic [3:0] q, qbar, toggled;
    logic       tc;

    int checks = 0;
    int errors = 0;

    logic [3:0] mq;
    logic [3:0] mt;

    always #5 clk = ~clk;

    cn_flipflop_bank #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .c         (c),
        .n         (n),
        .cnt_en    (cnt_en),
        .sclr      (sclr),
        .load      (load),
        .load_data (load_data),
`ifdef CN_STICKY_EN
        .sticky_clr(sticky_clr),
        .toggled   (toggled),
`endif
        .q         (q),
        .qbar      (qbar),
        .tc        (tc)
    );

`ifndef CN_STICKY_EN
    assign toggled = 4'b0000;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        mode = 1'b0; cnt_en = 1'b0; sclr = 1'b0; load = 1'b0; sticky_clr = 1'b0;
        c = 4'b0000; n = 4'b0000; load_data = 4'b0000;
    endtask

    // Reference: value-level rules (increment, per-bit truth table, changed-bit mask).
    task automatic cycle(input string tag);
        logic [3:0] nq, setv, nt;
        logic       etc;
        #1;
        etc = mode & cnt_en & (mq == 4'hF) & ~sclr & ~load;
        chk({tag, ".tc"}, {31'b0, tc}, {31'b0, etc});
        setv = 4'b0000;
        if (sclr) begin
            nq = 4'b0000;
        end else if (load) begin
            nq = load_data;
        end else if (mode) begin
            nq = cnt_en ? mq + 4'd1 : mq;
            if (cnt_en) setv = mq ^ nq;
        end else begin
            nq = mq;
            for (int i = 0; i < W; i++) begin
                if (n[i]) nq[i] = c[i] ? ~mq[i] : 1'b0;
            end
            setv = n & c;
        end
        nt = (sclr || sticky_clr) ? 4'b0000 : mt;
        nt = nt | setv;
        @(posedge clk);
        #1;
        mq = nq;
        mt = nt;
        chk({tag, ".q"}, {28'b0, q}, {28'b0, mq});
        chk({tag, ".qbar"}, {28'b0, qbar}, {28'b0, ~mq});
`ifdef CN_STICKY_EN
        chk({tag, ".toggled"}, {28'b0, toggled}, {28'b0, mt});
`endif
    endtask

    // Asserted between edges; q must follow without a clock.
    task automatic async_reset(input string tag);
        #3;
        reset = 1'b0;
        #1;
        mq = RV;
        mt = 4'b0000;
        chk({tag, ".q"}, {28'b0, q}, {28'b0, RV});
        chk({tag, ".qbar"}, {28'b0, qbar}, {28'b0, ~RV});
`ifdef CN_STICKY_EN
        chk({tag, ".toggled"}, {28'b0, toggled}, 32'd0);
`endif
        #1;
        reset = 1'b1;
        cycle({tag, ".resume"});
    endtask

    initial begin
        idle();
        mq = RV;
        mt = 4'b0000;
        #2;
        reset = 1'b0;
        #1;
        chk("rst_immediate.q", {28'b0, q}, {28'b0, RV});
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("rst_held.q", {28'b0, q}, 32'h0000000A);
            chk("rst_held.qbar", {28'b0, qbar}, 32'h00000005);
            chk("rst_held.tc", {31'b0, tc}, 32'd0);
        end
        reset = 1'b1;
        cycle("rst_release_hold");
        chk("rst_release_lit", {28'b0, q}, 32'h0000000A);

        load = 1'b1; load_data = 4'b0101;
        cycle("load_0101");
        idle(); n = 4'b1111; c = 4'b0011;
        cycle("bank_table");
        chk("bank_table_lit", {28'b0, q}, 32'h00000002);

        for (int k = 0; k < 3; k++) begin
            idle(); c = 4'($urandom);
            cycle("bank_hold");
        end
        chk("bank_hold_lit", {28'b0, q}, 32'h00000002);

        idle(); load = 1'b1; load_data = 4'b1101;
        cycle("load_1101");
        idle(); mode = 1'b1; cnt_en = 1'b1;
        for (int k = 0; k < 4; k++) cycle("count_wrap");
        chk("count_wrap_lit", {28'b0, q}, 32'h00000001);

        cnt_en = 1'b0;
        for (int k = 0; k < 2; k++) cycle("count_gated");

        idle(); load = 1'b1; load_data = 4'b1111; mode = 1'b1;
        cycle("load_ones");
        cnt_en = 1'b1; load = 1'b0; sclr = 1'b1;
        cycle("tc_masked_by_sclr");

        idle(); sclr = 1'b1; load = 1'b1; load_data = 4'b0111;
        cycle("prio_sclr_load");
        chk("prio_lit", {28'b0, q}, 32'd0);

        idle(); mode = 1'b1; cnt_en = 1'b1;
        cycle("pre_async");
        cycle("pre_async");
        async_reset("async_mid");

        idle(); sticky_clr = 1'b1;
        cycle("sticky_clr0");
        idle(); n = 4'b0100; c = 4'b0100;
        cycle("sticky_set");
`ifdef CN_STICKY_EN
        chk("sticky_set_lit", {28'b0, toggled}, 32'h00000004);
`endif
        idle(); load = 1'b1; load_data = ~mq;
        cycle("sticky_load");
        idle(); sticky_clr = 1'b1;
        cycle("sticky_clr");
        idle(); sticky_clr = 1'b1; n = 4'b0001; c = 4'b0001;
        cycle("sticky_set_wins");

        for (int k = 0; k < 300; k++) begin
            mode       = 1'($urandom);
            c          = 4'($urandom);
            n          = 4'($urandom);
            cnt_en     = ($urandom_range(0, 3) != 0);
            sclr       = ($urandom_range(0, 15) == 0);
            load       = ($urandom_range(0, 9) == 0);
            load_data  = 4'($urandom);
            sticky_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 49) == 0) async_reset("rand_async");
            else cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
